// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default byte width, index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int UART_DATA_W = 8;

  // Width of an index into n items; never below 1 so a single-item case still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Rotate so bit 0 is the pointer position, take the lowest set bit, map back mod N.
  always_comb begin
    logic [2*N-1:0] dbl;
    logic [IW:0]    sum;
    dbl     = {req_i, req_i} >> ptr_i;
    sum     = '0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        found_o = 1'b1;
        sum     = {1'b0, ptr_i} + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
        idx_o   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART transmitter among NUM_REQ requesters.
// A grant lasts until the owner's last byte, MAX_BURST bytes, or the owner dropping req.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = UART_DATA_W,
  parameter  int MAX_BURST = 16,
  localparam int IDX_W     = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy
);

  localparam int BC_W = idx_w(MAX_BURST);

  state_e                            state_q, state_d;
  logic   [IDX_W-1:0]                grant_q, grant_d;
  logic   [IDX_W-1:0]                ptr_q, ptr_d;
  logic   [DATA_W-1:0]               data_q, data_d;
  logic                              last_q, last_d;
  logic   [BC_W-1:0]                 bcnt_q, bcnt_d;

  logic   [NUM_REQ-1:0][DATA_W-1:0]  req_bytes;
  logic                              arb_found;
  logic   [IDX_W-1:0]                arb_idx;
  logic                              release_c;
  logic   [IDX_W-1:0]                ptr_next;

  assign req_bytes = req_data;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // Owner gives up the transmitter after its last byte, a full burst, or when it stops requesting.
  assign release_c = last_q || (bcnt_q == BC_W'(MAX_BURST - 1)) || !req[grant_q];
  assign ptr_next  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // State and datapath registers; reset abandons any byte in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next state: arbitrate in IDLE, pulse in START, wait for tx_done and either continue or release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          data_d  = req_bytes[arb_idx];
          last_d  = req_last[arb_idx];
          bcnt_d  = '0;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (release_c) begin
            ptr_d   = ptr_next;
            state_d = IDLE;
          end else begin
            data_d  = req_bytes[grant_q];
            last_d  = req_last[grant_q];
            bcnt_d  = bcnt_q + BC_W'(1);
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: start/ack pulse only in START, busy outside IDLE.
  always_comb begin
    ack      = '0;
    tx_start = (state_q == START);
    busy     = (state_q != IDLE);
    if (state_q == START) ack[grant_q] = 1'b1;
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, directed multi-cycle scenarios,
// and randomized message mixes checked against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    ack;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [3:0]  lst;
    logic [31:0] d;
    logic        dn;
    logic [3:0]  e_ack;
    logic        e_st;
    logic [7:0]  e_d;
    logic [1:0]  e_g;
    logic        e_busy;
  } vec_t;
  vec_t tv[12];

  // ---------------- requester / transmitter models ----------------
  typedef struct packed { logic [7:0] d; logic l; } byte_t;
  typedef struct packed { logic [1:0] id; logic [7:0] d; } sent_t;

  byte_t      rq[N][$];
  sent_t      log_q[$];
  sent_t      exp_q[$];
  logic [N-1:0] hold = '0;
  logic       txb = 1'b0;
  int         txc = 0;
  int         lat_max = 2;
  logic [7:0] cur = '0;
  logic       spur = 1'b0;

  task automatic put(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({d, l});
  endtask

  task automatic ex(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  function automatic int pending();
    int t = 0;
    for (int i = 0; i < N; i++) t += rq[i].size();
    return t;
  endfunction

  // One cycle at the falling edge: observe outputs, react as requesters and transmitter, advance.
  task automatic cycle();
    if (tx_start) begin
      chk("start_while_tx_busy", 32'(txb), 0);
      chk("ack_matches_grant", 32'(ack), 32'(4'(1) << grant_id));
      log_q.push_back({grant_id, tx_data});
      cur = tx_data;
      txb = 1'b1;
      txc = $urandom_range(lat_max, 0);
    end else begin
      chk("ack_outside_start", 32'(ack), 0);
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        chk($sformatf("ack%0d_has_byte", i), 32'(rq[i].size() > 0), 1);
        if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
    end
    tx_done = 1'b0;
    if (txb && !tx_start) begin
      chk("tx_data_hold", 32'(tx_data), 32'(cur));
      if (txc == 0) begin
        tx_done = 1'b1;
        txb = 1'b0;
      end else txc--;
    end else if (spur) tx_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      req[i] = (rq[i].size() > 0) && !hold[i];
      if (rq[i].size() > 0) begin
        req_data[i*DW +: DW] = rq[i][0].d;
        req_last[i] = rq[i][0].l;
      end else req_last[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (!(pending() == 0 && !txb && !busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("run_idle_timeout", 32'(n < budget), 1);
  endtask

  task automatic run_log(input int cnt, input int budget);
    int n = 0;
    while (log_q.size() < cnt && n < budget) begin
      cycle();
      n++;
    end
    chk("run_log_timeout", 32'(n < budget), 1);
  endtask

  task automatic cmp_log(input string nm);
    chk({nm, ".count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s.byte%0d", nm, i), 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; req_last = '0; tx_done = 1'b0;
    hold = '0; spur = 1'b0; txb = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    log_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Message-level expectation: owner = first pending requester from the pointer; it keeps the
  // transmitter until a last byte, MB bytes, or its queue runs dry; pointer moves past it.
  task automatic model();
    byte_t c[N][$];
    byte_t b;
    int    p = 0;
    int    o;
    int    n;
    int    tot;
    logic  done;
    for (int i = 0; i < N; i++) c[i] = rq[i];
    tot = pending();
    while (tot > 0) begin
      o = 0;
      for (int k = N - 1; k >= 0; k--) if (c[(p + k) % N].size() > 0) o = (p + k) % N;
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = c[o].pop_front();
        exp_q.push_back({2'(o), b.d});
        n++;
        tot--;
        done = b.l || (n == MB) || (c[o].size() == 0);
      end
      p = (o + 1) % N;
    end
  endtask

  initial begin
    // rst, req, last, data, tx_done -> ack, tx_start, tx_data, grant_id, busy after next edge
    tv[0]  = '{1'b0, 4'h0, 4'h0, 32'h0000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    tv[1]  = '{1'b1, 4'h1, 4'h1, 32'h0041, 1'b0, 4'h1, 1'b1, 8'h41, 2'd0, 1'b1};
    tv[2]  = '{1'b1, 4'h0, 4'h0, 32'h0041, 1'b0, 4'h0, 1'b0, 8'h41, 2'd0, 1'b1};
    tv[3]  = '{1'b1, 4'h0, 4'h0, 32'h0041, 1'b1, 4'h0, 1'b0, 8'h41, 2'd0, 1'b0};
    tv[4]  = '{1'b1, 4'h3, 4'h3, 32'h5241, 1'b0, 4'h2, 1'b1, 8'h52, 2'd1, 1'b1};
    tv[5]  = '{1'b1, 4'h1, 4'h1, 32'h5241, 1'b0, 4'h0, 1'b0, 8'h52, 2'd1, 1'b1};
    tv[6]  = '{1'b1, 4'h1, 4'h1, 32'h5241, 1'b1, 4'h0, 1'b0, 8'h52, 2'd1, 1'b0};
    tv[7]  = '{1'b1, 4'h1, 4'h1, 32'h5241, 1'b0, 4'h1, 1'b1, 8'h41, 2'd0, 1'b1};
    tv[8]  = '{1'b1, 4'h0, 4'h0, 32'h5241, 1'b0, 4'h0, 1'b0, 8'h41, 2'd0, 1'b1};
    tv[9]  = '{1'b1, 4'h0, 4'h0, 32'h5241, 1'b1, 4'h0, 1'b0, 8'h41, 2'd0, 1'b0};
    tv[10] = '{1'b1, 4'h0, 4'h0, 32'h0000, 1'b1, 4'h0, 1'b0, 8'h41, 2'd0, 1'b0};
    tv[11] = '{1'b1, 4'h0, 4'h0, 32'h0000, 1'b0, 4'h0, 1'b0, 8'h41, 2'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      reset_n  = tv[i].rst;
      req      = tv[i].rq;
      req_last = tv[i].lst;
      req_data = tv[i].d;
      tx_done  = tv[i].dn;
      @(negedge clk);
      chk($sformatf("vec%0d.ack", i),   32'(ack),      32'(tv[i].e_ack));
      chk($sformatf("vec%0d.start", i), 32'(tx_start), 32'(tv[i].e_st));
      chk($sformatf("vec%0d.busy", i),  32'(busy),     32'(tv[i].e_busy));
      if (tv[i].e_busy || !tv[i].rst) begin
        chk($sformatf("vec%0d.data", i),  32'(tx_data),  32'(tv[i].e_d));
        chk($sformatf("vec%0d.grant", i), 32'(grant_id), 32'(tv[i].e_g));
      end
    end

    // All four at once, then a wrapped round starting again at 0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      put(i, 8'h30 + 8'(i), 1'b1);
      ex(i, 8'h30 + 8'(i));
    end
    run_idle(300);
    cmp_log("rr4");
    put(3, 8'h63, 1'b1); put(0, 8'h60, 1'b1);
    ex(0, 8'h60); ex(3, 8'h63);
    run_idle(300);
    cmp_log("rr_wrap");

    // Message lock: req1 waits for the whole 3-byte message of req0.
    do_reset();
    put(0, 8'h10, 1'b0); put(0, 8'h11, 1'b0); put(0, 8'h12, 1'b1); put(1, 8'h20, 1'b1);
    ex(0, 8'h10); ex(0, 8'h11); ex(0, 8'h12); ex(1, 8'h20);
    run_idle(300);
    cmp_log("lock");

    // Burst cut-off after MB bytes hands over to req2, then req0 resumes.
    do_reset();
    for (int k = 0; k < 6; k++) put(0, 8'hA0 + 8'(k), 1'b0);
    put(2, 8'hC0, 1'b1);
    for (int k = 0; k < 4; k++) ex(0, 8'hA0 + 8'(k));
    ex(2, 8'hC0); ex(0, 8'hA4); ex(0, 8'hA5);
    run_idle(400);
    cmp_log("burst");

    // Reset while waiting for tx_done.
    do_reset();
    put(1, 8'h71, 1'b1);
    ex(1, 8'h71);
    run_idle(200);
    cmp_log("pre_reset_msg");
    put(2, 8'h72, 1'b1); put(2, 8'h73, 1'b1);
    begin
      int n = 0;
      while (!txb && n < 20) begin cycle(); n++; end
      chk("reach_wait_timeout", 32'(n < 20), 1);
    end
    txc = 100;
    chk("pre_reset_busy", 32'(busy), 1);
    reset_n = 1'b0;
    req = '0; req_last = '0; tx_done = 1'b0; txb = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    log_q.delete();
    #1;
    chk("rst_async.busy",  32'(busy),     0);
    chk("rst_async.start", 32'(tx_start), 0);
    chk("rst_async.ack",   32'(ack),      0);
    chk("rst_async.data",  32'(tx_data),  0);
    chk("rst_async.grant", 32'(grant_id), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold.busy", 32'(busy), 0);
      chk("rst_hold.ack",  32'(ack),  0);
    end
    reset_n = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    chk("rst_spur.ack",   32'(ack),      0);
    chk("rst_spur.start", 32'(tx_start), 0);
    chk("rst_spur.busy",  32'(busy),     0);
    put(3, 8'h83, 1'b1); put(0, 8'h80, 1'b1);
    ex(0, 8'h80); ex(3, 8'h83);
    run_idle(200);
    cmp_log("post_reset");

    // Spurious tx_done in IDLE, then req0 drops req between bytes.
    do_reset();
    spur = 1'b1;
    repeat (3) begin
      cycle();
      chk("spur_idle.start", 32'(tx_start), 0);
      chk("spur_idle.busy",  32'(busy),     0);
    end
    spur = 1'b0;
    put(0, 8'hB0, 1'b0); put(0, 8'hB1, 1'b0); put(0, 8'hB2, 1'b1); put(1, 8'hD0, 1'b1);
    ex(0, 8'hB0); ex(1, 8'hD0); ex(0, 8'hB1); ex(0, 8'hB2);
    run_log(1, 50);
    hold[0] = 1'b1;
    run_log(2, 50);
    hold[0] = 1'b0;
    run_idle(300);
    cmp_log("drop");

    // Randomized message mixes against the message-level model.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      lat_max = $urandom_range(3, 0);
      for (int i = 0; i < N; i++) begin
        int nm = $urandom_range(3, 0);
        for (int m = 0; m < nm; m++) begin
          int len = $urandom_range(6, 1);
          for (int k = 0; k < len; k++) put(i, 8'($urandom), k == len - 1);
        end
      end
      model();
      run_idle(3000);
      cmp_log($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
